// File: rtl/switch_reader_if.sv
// Shared 8-bit peripheral bus: address, write strobe, resolved data lines
// and the interrupt request/acknowledge pair.
interface switch_reader_if;
  logic [7:0] addr;
  logic       we;
  logic       ack;
  logic       irq;
  logic [7:0] m_data;
  logic       m_oe;
  logic [7:0] s_data;
  logic       s_oe;
  wire  [7:0] data;

  // The bus master owns the lines during its own writes; otherwise the peripheral may drive them.
  assign data = m_oe ? m_data : (s_oe ? s_data : 8'hzz);

  modport master (output addr, we, ack, m_data, m_oe, input irq, data, s_oe);
  modport slave  (input addr, we, ack, data, output irq, s_data, s_oe);
endinterface

// File: rtl/switch_reader.sv
// Switch input peripheral: 2-FF synchroniser, per-bit debouncer, sticky
// change register with write-1-to-clear, bus read-back and level interrupt.
module switch_reader #(
  parameter logic [7:0] BASE_ADDR       = 8'hE0,
  parameter int         DEBOUNCE_CYCLES = 50000,
  parameter int         CNT_W           = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [7:0]     sw_in,
  switch_reader_if.slave bus
);
  // state  | meaning
  // IDLE   | no interrupt outstanding
  // RAISED | interrupt asserted, waiting for ack
  typedef enum logic {IDLE = 1'b0, RAISED = 1'b1} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0]       CHG_ADDR = BASE_ADDR + 8'd1;

  state_t           state, state_nxt;
  logic [7:0]       sw_meta, sw_sync, stable, chg, toggle, clr, dout;
  logic [CNT_W-1:0] cnt [8];
  logic             pending, pending_nxt, oe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= sw_in;
      sw_sync <= sw_meta;
    end
  end

  always_comb begin
    toggle = '0;
    for (int i = 0; i < 8; i++)
      toggle[i] = (sw_sync[i] != stable[i]) && (cnt[i] == CNT_LAST);
  end

  // Counter restarts whenever the input agrees with the accepted level or a new level is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable <= '0;
      for (int i = 0; i < 8; i++) cnt[i] <= '0;
    end else begin
      stable <= stable ^ toggle;
      for (int i = 0; i < 8; i++) begin
        if (sw_sync[i] == stable[i] || toggle[i]) cnt[i] <= '0;
        else                                       cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end

  assign clr = (bus.we && bus.addr == CHG_ADDR) ? bus.data : 8'h00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chg <= '0;
    else        chg <= (chg & ~clr) | toggle;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pending <= 1'b0;
    end else begin
      state   <= state_nxt;
      pending <= pending_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    pending_nxt = pending | (|toggle);
    case (state)
      IDLE: begin
        if (pending) begin
          state_nxt   = RAISED;
          pending_nxt = |toggle;
        end
      end
      RAISED: begin
        if (bus.ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.irq = (state == RAISED);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout <= '0;
      oe   <= 1'b0;
    end else if (!bus.we && bus.addr == BASE_ADDR) begin
      dout <= stable;
      oe   <= 1'b1;
    end else if (!bus.we && bus.addr == CHG_ADDR) begin
      dout <= chg;
      oe   <= 1'b1;
    end else begin
      oe   <= 1'b0;
    end
  end

  assign bus.s_data = dout;
  assign bus.s_oe   = oe;
endmodule

// File: tb/tb_switch_reader.sv
// Bench for switch_reader: directed scenarios plus randomized traffic
// checked against a window-based behavioural model.
module tb_switch_reader;
  localparam int         D    = 4;
  localparam logic [7:0] BASE = 8'hE0;
  localparam logic [7:0] CHG  = 8'hE1;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] sw_in = 8'h00;
  int vectors = 0;
  int errors  = 0;

  switch_reader_if bus();

  switch_reader #(.BASE_ADDR(BASE), .DEBOUNCE_CYCLES(D), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .sw_in(sw_in), .bus(bus.slave));

  always #5 clk = ~clk;

  // Model: a bit accepts a new level once the last D synchronised samples,
  // all taken after its previous acceptance, disagree with the current level.
  logic [7:0] m_s1, m_s2, m_stable, m_chg, m_dout, m_tog, m_clr;
  logic       m_oe, m_irq, m_pend, m_all;
  logic [7:0] m_hist [$];
  int         m_last_flip [8];
  int         m_n;

  task automatic model_step();
    if (!rst_n) begin
      m_s1 = 0; m_s2 = 0; m_stable = 0; m_chg = 0; m_dout = 0;
      m_oe = 0; m_irq = 0; m_pend = 0;
      m_hist.delete();
      for (int i = 0; i < 8; i++) m_last_flip[i] = -1;
    end else begin
      m_hist.push_back(m_s2);
      m_n   = m_hist.size() - 1;
      m_tog = 8'h00;
      for (int i = 0; i < 8; i++) begin
        if (m_n - m_last_flip[i] >= D) begin
          m_all = 1'b1;
          for (int k = 0; k < D; k++)
            if (m_hist[m_n-k][i] == m_stable[i]) m_all = 1'b0;
          if (m_all) begin
            m_tog[i] = 1'b1;
            m_last_flip[i] = m_n;
          end
        end
      end
      if (!bus.we && bus.addr == BASE) begin m_dout = m_stable; m_oe = 1; end
      else if (!bus.we && bus.addr == CHG) begin m_dout = m_chg; m_oe = 1; end
      else m_oe = 0;
      m_clr    = (bus.we && bus.addr == CHG && bus.m_oe) ? bus.m_data : 8'h00;
      m_chg    = (m_chg & ~m_clr) | m_tog;
      m_stable = m_stable ^ m_tog;
      if (!m_irq) begin
        if (m_pend) begin m_irq = 1; m_pend = |m_tog; end
        else m_pend = |m_tog;
      end else begin
        if (bus.ack) m_irq = 0;
        m_pend = m_pend | (|m_tog);
      end
      m_s2 = m_s1;
      m_s1 = sw_in;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      model_step();
    end
  end

  task automatic bus_idle();
    bus.we = 0; bus.addr = 8'h00; bus.m_oe = 0; bus.m_data = 8'h00; bus.ack = 0;
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    bus.we = 1; bus.addr = a; bus.m_data = d; bus.m_oe = 1;
    @(negedge clk);
    bus_idle();
  endtask

  task automatic ack_pulse();
    bus.ack = 1;
    @(negedge clk);
    bus.ack = 0;
  endtask

  task automatic test_reset();
    rst_n = 0; sw_in = 8'h00; bus_idle();
    repeat (3) @(negedge clk);
    vectors++; if (bus.s_oe !== 1'b0) begin errors++; $display("FAIL reset_oe: got %b want 0", bus.s_oe); end
    vectors++; if (bus.irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b want 0", bus.irq); end
    rst_n = 1; bus.addr = BASE;
    @(negedge clk);
    vectors++; if (bus.s_oe !== 1'b1) begin errors++; $display("FAIL reset_read_oe: got %b want 1", bus.s_oe); end
    vectors++; if (bus.data !== 8'h00) begin errors++; $display("FAIL reset_read_data: got %h want 00", bus.data); end
    bus_idle();
  endtask

  task automatic test_clean_edge();
    bus.addr = BASE; sw_in = 8'h5A;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 6) begin
        vectors++; if (bus.data !== 8'h00) begin errors++; $display("FAIL clean_early: got %h want 00", bus.data); end
        vectors++; if (bus.irq !== 1'b0) begin errors++; $display("FAIL clean_irq_early: got %b want 0", bus.irq); end
      end
      if (k == 7) begin
        vectors++; if (bus.data !== 8'h5A) begin errors++; $display("FAIL clean_level: got %h want 5a", bus.data); end
        vectors++; if (bus.irq !== 1'b1) begin errors++; $display("FAIL clean_irq: got %b want 1", bus.irq); end
      end
    end
    bus.addr = CHG;
    @(negedge clk);
    vectors++; if (bus.data !== 8'h5A) begin errors++; $display("FAIL clean_chg: got %h want 5a", bus.data); end
    bus.addr = 8'h00;
    ack_pulse();
    vectors++; if (bus.irq !== 1'b0) begin errors++; $display("FAIL clean_ack: got %b want 0", bus.irq); end
    bus_write(CHG, 8'hFF);
  endtask

  task automatic test_bounce();
    int   changes = 0;
    int   first = -1;
    logic prev;
    bus.addr = BASE;
    @(negedge clk);
    prev = bus.data[0];
    for (int t = 0; t < 40; t++) begin
      if (t < 20 && t % 2 == 0) sw_in[0] = ~sw_in[0];
      if (t == 20) sw_in[0] = 1'b1;
      @(negedge clk);
      if (bus.data[0] !== prev) begin
        changes++;
        if (first < 0) first = t;
        prev = bus.data[0];
      end
    end
    vectors++; if (changes != 1) begin errors++; $display("FAIL bounce_changes: got %0d want 1", changes); end
    vectors++; if (first != 26) begin errors++; $display("FAIL bounce_timing: got %0d want 26", first); end
    bus.addr = CHG;
    @(negedge clk);
    vectors++; if (bus.data !== 8'h01) begin errors++; $display("FAIL bounce_chg: got %h want 01", bus.data); end
    bus.addr = 8'h00;
    ack_pulse();
    bus_write(CHG, 8'hFF);
  endtask

  task automatic test_irq_requeue();
    int w = 0;
    sw_in[7] = ~sw_in[7];
    while (bus.irq !== 1'b1 && w < 20) begin @(negedge clk); w++; end
    vectors++; if (bus.irq !== 1'b1) begin errors++; $display("FAIL irq_first: got %b want 1", bus.irq); end
    sw_in[7] = ~sw_in[7];
    repeat (8) @(negedge clk);
    vectors++; if (bus.irq !== 1'b1) begin errors++; $display("FAIL irq_held: got %b want 1", bus.irq); end
    ack_pulse();
    vectors++; if (bus.irq !== 1'b0) begin errors++; $display("FAIL irq_drop: got %b want 0", bus.irq); end
    @(negedge clk);
    vectors++; if (bus.irq !== 1'b1) begin errors++; $display("FAIL irq_requeue: got %b want 1", bus.irq); end
    ack_pulse();
    vectors++; if (bus.irq !== 1'b0) begin errors++; $display("FAIL irq_second_ack: got %b want 0", bus.irq); end
    ack_pulse();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      vectors++; if (bus.irq !== 1'b0) begin errors++; $display("FAIL irq_quiet: got %b want 0", bus.irq); end
    end
    bus_write(CHG, 8'hFF);
  endtask

  task automatic test_w1c();
    sw_in = sw_in ^ 8'h5A;
    repeat (8) @(negedge clk);
    bus.addr = CHG;
    @(negedge clk);
    vectors++; if (bus.data !== 8'h5A) begin errors++; $display("FAIL w1c_initial: got %h want 5a", bus.data); end
    bus_write(CHG, 8'h0A);
    bus.addr = CHG;
    @(negedge clk);
    vectors++; if (bus.data !== 8'h50) begin errors++; $display("FAIL w1c_clear: got %h want 50", bus.data); end
    bus.addr = 8'h00;
    sw_in = sw_in ^ 8'h02;
    repeat (5) @(negedge clk);
    bus_write(CHG, 8'h02);
    bus.addr = CHG;
    @(negedge clk);
    vectors++; if (bus.data !== 8'h52) begin errors++; $display("FAIL w1c_set_wins: got %h want 52", bus.data); end
    bus_write(BASE, 8'hFF);
    bus.addr = CHG;
    @(negedge clk);
    vectors++; if (bus.data !== 8'h52) begin errors++; $display("FAIL w1c_base_write_chg: got %h want 52", bus.data); end
    bus.addr = BASE;
    @(negedge clk);
    vectors++; if (bus.data !== sw_in) begin errors++; $display("FAIL w1c_base_write_level: got %h want %h", bus.data, sw_in); end
    bus.addr = 8'h00;
    ack_pulse();
    bus_write(CHG, 8'hFF);
    repeat (3) @(negedge clk);
    if (bus.irq === 1'b1) ack_pulse();
  endtask

  task automatic test_bus_z();
    bus.addr = BASE;
    @(negedge clk);
    bus.addr = 8'hE2;
    @(negedge clk);
    vectors++; if (bus.s_oe !== 1'b0) begin errors++; $display("FAIL z_other_addr: got %b want 0", bus.s_oe); end
    bus.addr = BASE;
    @(negedge clk);
    bus.we = 1; bus.m_data = 8'h00;
    @(negedge clk);
    vectors++; if (bus.s_oe !== 1'b0) begin errors++; $display("FAIL z_write: got %b want 0", bus.s_oe); end
    bus_idle();
  endtask

  task automatic test_reset_mid();
    sw_in = 8'hA5;
    repeat (3) @(negedge clk);
    rst_n = 0; bus.addr = BASE;
    #1;
    vectors++; if (bus.irq !== 1'b0) begin errors++; $display("FAIL mid_reset_irq: got %b want 0", bus.irq); end
    vectors++; if (bus.s_oe !== 1'b0) begin errors++; $display("FAIL mid_reset_oe: got %b want 0", bus.s_oe); end
    @(negedge clk);
    rst_n = 1; bus.addr = CHG;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 1) begin
        vectors++; if (bus.data !== 8'h00) begin errors++; $display("FAIL mid_chg_cleared: got %h want 00", bus.data); end
      end
      if (k == 6) begin
        vectors++; if (bus.irq !== 1'b0) begin errors++; $display("FAIL mid_irq_early: got %b want 0", bus.irq); end
      end
      if (k == 7) begin
        vectors++; if (bus.irq !== 1'b1) begin errors++; $display("FAIL mid_irq: got %b want 1", bus.irq); end
        vectors++; if (bus.data !== 8'hA5) begin errors++; $display("FAIL mid_chg: got %h want a5", bus.data); end
      end
    end
    bus.addr = 8'h00;
    ack_pulse();
    bus_write(CHG, 8'hFF);
  endtask

  task automatic test_random();
    int r;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      vectors++; if (bus.irq !== m_irq) begin errors++; $display("FAIL rand_irq cycle %0d: got %b want %b", c, bus.irq, m_irq); end
      vectors++; if (bus.s_oe !== m_oe) begin errors++; $display("FAIL rand_oe cycle %0d: got %b want %b", c, bus.s_oe, m_oe); end
      if (m_oe && !bus.m_oe) begin
        vectors++; if (bus.data !== m_dout) begin errors++; $display("FAIL rand_data cycle %0d: got %h want %h", c, bus.data, m_dout); end
      end
      if ($urandom_range(0, 5) == 0) sw_in = sw_in ^ (8'd1 << $urandom_range(0, 7));
      bus_idle();
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2, 3: bus.addr = BASE;
        4, 5:       bus.addr = CHG;
        6: begin bus.we = 1; bus.addr = CHG;  bus.m_data = 8'($urandom_range(0, 255)); bus.m_oe = 1; end
        7: begin bus.we = 1; bus.addr = BASE; bus.m_data = 8'($urandom_range(0, 255)); bus.m_oe = 1; end
        8: bus.addr = 8'($urandom_range(0, 255));
        default: ;
      endcase
      bus.ack = ($urandom_range(0, 7) == 0);
    end
    bus_idle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_clean_edge();
    test_bounce();
    test_irq_requeue();
    test_w1c();
    test_bus_z();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
